branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and redirect unit with a direct-mapped BTB and 2-bit saturating counters. In IF it looks up the fetch PC and supplies a predicted next PC. In EX it consumes the resolved `taken` from `branch_logic`, detects mispredictions, generates the flush/redirect PC and trains its tables. It also keeps branch and mispredict statistics counters.

## Interface
- `ENTRIES`, 16, number of BTB entries; must be a power of 2, minimum 2.
- `IDX_W`, $clog2(ENTRIES), index width; derived, do not override.
- `clk` in 1, rising-edge clock.
- `rst` in 1, reset; synchronous, active-high.
- `if_pc` in 32, fetch PC to predict.
- `pred_taken` out 1, prediction for `if_pc`.
- `pred_target` out 32, predicted next PC for `if_pc`.
- `ex_valid` in 1, EX-stage instruction is valid.
- `ex_branch` in 1, EX instruction is a conditional branch; same signal as `branch_logic.branch`.
- `ex_taken` in 1, resolved outcome, driven by `branch_logic.taken`.
- `ex_pc` in 32, PC of the EX instruction.
- `ex_target` in 32, computed branch target, `ex_pc` + B-immediate.
- `ex_pred_taken` in 1, `pred_taken` carried down the pipe with the instruction.
- `ex_pred_target` in 32, `pred_target` carried down the pipe with the instruction.
- `mispredict` out 1, flush IF/ID and redirect fetch.
- `redirect_pc` out 32, correct next PC; valid only when `mispredict`=1.
- `branch_cnt` out 32, number of resolved branches.
- `mispred_cnt` out 32, number of mispredictions.

## Operation
- **Address fields:** index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- **Per-entry state:** valid bit, tag, 32-bit target, 2-bit counter.
- **Counter states:** SNT=00, WNT=01, WT=10, ST=11. Counter bit 1 is the direction prediction.
- **Lookup (combinational from registered tables):**
  - hit = valid[idx] && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = `pred_taken` ? stored target : `if_pc`+4.
- **Resolution (combinational):** upd = `ex_valid` && `ex_branch`.
  - `mispredict` = upd && (`ex_taken` != `ex_pred_taken` || (`ex_taken` && `ex_target` != `ex_pred_target`)).
  - `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4.
- **Non-branch predicted taken:** when `ex_valid` && !`ex_branch` && `ex_pred_taken`:
  - `mispredict`=1 and `redirect_pc` = `ex_pc`+4.
  - On the next edge, the entry for `ex_pc` is invalidated if its tag matches.
- **Training, at the edge when upd=1:**
  - **EX hit, taken:** counter increments, saturating at ST; target is overwritten with `ex_target`.
  - **EX hit, not taken:** counter decrements, saturating at SNT; target is unchanged.
  - **EX miss, taken:** allocate/replace the entry: valid=1, tag, target=`ex_target`, ctr=WT.
  - **EX miss, not taken:** no change to the table.
- **Statistics:**
  - `branch_cnt` +1 on every upd.
  - `mispred_cnt` +1 on every cycle where `mispredict`=1, including the non-branch case.
  - Both counters wrap from 0xFFFFFFFF to 0.
- **Invalid lines:** `ex_valid`=0 means no update, no count and `mispredict`=0, whatever the other EX inputs are.

## Timing
- **Lookup:** 0-cycle latency; `pred_*` depend on `if_pc` and the registered state only.
- **Mispredict:** `mispredict`/`redirect_pc` are 0-cycle from the EX inputs. The pipeline flushes and loads `redirect_pc` at the same edge.
- **Training:** table and counter updates are visible on lookup from the cycle after the update edge.
- **Same-cycle read and update of one index:** the lookup returns the pre-update contents; there is no bypass.
- **Reset:**
  - All valid=0, counters=WNT, targets/tags=0, `branch_cnt`=`mispred_cnt`=0.
  - Outputs during and after reset: `pred_taken`=0, `pred_target`=`if_pc`+4. `mispredict` still follows its combinational EX equation.
  - `rst` takes priority over any same-cycle update.
  - `rst` asserted mid-stream discards that cycle's training and count increments.
- **PC wrap:** `if_pc`+4 and `ex_pc`+4 wrap modulo 2^32. For example, 0xFFFFFFFC gives 0x00000000.

## Test plan
All scenarios use ENTRIES=16.
- **Reset:** pulse `rst`, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `branch_cnt`=`mispred_cnt`=0.
- **Cold taken:** `ex_pc`=0x100, `ex_target`=0x80, `ex_taken`=1, `ex_pred_taken`=0 → `mispredict`=1, `redirect_pc`=0x80. Next cycle `if_pc`=0x100 → `pred_taken`=1, `pred_target`=0x80. Counts are 1/1.
- **Hysteresis:** after the cold-taken case, 2 more taken updates (correctly predicted, no mispredict), so ctr=ST. Then a not-taken update with pred_taken=1 → `mispredict`=1, `redirect_pc`=0x104, and the entry still predicts taken (WT). A second not-taken update → the entry predicts not-taken (WNT).
- **Alias/tag:** entry for 0x100 valid and taken; `if_pc`=0x140 (same index 0, different tag) → `pred_taken`=0, `pred_target`=0x144.
- **Non-branch predicted taken:** `ex_valid`=1, `ex_branch`=0, `ex_pred_taken`=1, `ex_pc`=0x100 → `mispredict`=1, `redirect_pc`=0x104. Next cycle `if_pc`=0x100 → `pred_taken`=0. `branch_cnt` is unchanged.
- **Reset mid-operation:** assert `rst` in the same cycle as a taken update for 0x200 → next cycle `if_pc`=0x200 gives `pred_taken`=0, and both counts are 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Predicts the next fetch PC in IF and resolves, redirects and trains in EX.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [31:0]      target_reg [ENTRIES];
    logic [1:0]       ctr_reg    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_tag_match, ex_hit;
    logic             upd, nb_flush;
    logic [31:0]      ex_pc_plus4;
    logic [ENTRIES-1:0] sel;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    assign if_hit      = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_reg[if_idx][1];
    assign pred_target = pred_taken ? target_reg[if_idx] : if_pc + 32'd4;

    assign ex_tag_match = (tag_reg[ex_idx] == ex_tag);
    assign ex_hit       = valid_reg[ex_idx] && ex_tag_match;
    assign upd          = ex_valid && ex_branch;
    // A non-branch that fetch steered away must be flushed and its stale entry dropped
    assign nb_flush     = ex_valid && !ex_branch && ex_pred_taken;
    assign ex_pc_plus4  = ex_pc + 32'd4;

    assign mispredict  = (upd && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_target != ex_pred_target))))
                         || nb_flush;
    assign redirect_pc = (ex_taken && !nb_flush) ? ex_target : ex_pc_plus4;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
            assign sel[gi] = (ex_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (sel[i]) begin
                    if (upd) begin
                        if (ex_hit) begin
                            if (ex_taken) begin
                                ctr_reg[i]    <= (ctr_reg[i] == CTR_ST) ? CTR_ST : ctr_reg[i] + 2'd1;
                                target_reg[i] <= ex_target;
                            end else begin
                                ctr_reg[i] <= (ctr_reg[i] == CTR_SNT) ? CTR_SNT : ctr_reg[i] - 2'd1;
                            end
                        end else if (ex_taken) begin
                            valid_reg[i]  <= 1'b1;
                            tag_reg[i]    <= ex_tag;
                            target_reg[i] <= ex_target;
                            ctr_reg[i]    <= CTR_WT;
                        end
                    end else if (nb_flush && ex_tag_match) begin
                        valid_reg[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd)        branch_cnt  <= branch_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of branch_predictor lookup, resolution, training, statistics and reset.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    int vectors = 0;
    int errors  = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic br, input logic tk, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid = v; ex_branch = br; ex_taken = tk; ex_pc = pc;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic ex_idle();
        ex_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, "_target"}, pred_target, tgt);
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        ex_idle();
        step();
        look("rst_during", 32'h100, 1'b0, 32'h104);
        step();
        rst = 1'b0;
        #1;
        look("reset", 32'h100, 1'b0, 32'h104);
        chk("reset_bcnt", branch_cnt, 32'd0);
        chk("reset_mcnt", mispred_cnt, 32'd0);

        // cold taken
        ex_set(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        chk("cold_mis", {31'd0, mispredict}, 32'd1);
        chk("cold_redir", redirect_pc, 32'h80);
        look("cold_presame", 32'h100, 1'b0, 32'h104);
        step();
        ex_idle();
        look("cold_after", 32'h100, 1'b1, 32'h80);
        chk("cold_bcnt", branch_cnt, 32'd1);
        chk("cold_mcnt", mispred_cnt, 32'd1);

        // two correctly predicted taken updates -> ST
        repeat (2) begin
            ex_set(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
            chk("hyst_tk_mis", {31'd0, mispredict}, 32'd0);
            step();
        end
        // taken but wrong target is still a mispredict
        ex_set(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h88);
        chk("tgt_mis", {31'd0, mispredict}, 32'd1);
        ex_set(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        chk("hyst_nt1_mis", {31'd0, mispredict}, 32'd1);
        chk("hyst_nt1_redir", redirect_pc, 32'h104);
        step();
        ex_idle();
        look("hyst_wt", 32'h100, 1'b1, 32'h80);
        ex_set(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        step();
        ex_idle();
        look("hyst_wnt", 32'h100, 1'b0, 32'h104);
        chk("hyst_bcnt", branch_cnt, 32'd5);
        chk("hyst_mcnt", mispred_cnt, 32'd3);

        // retrain toward taken (WNT -> WT), then alias check
        ex_set(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        step();
        ex_idle();
        look("alias_own", 32'h100, 1'b1, 32'h80);
        look("alias_other", 32'h140, 1'b0, 32'h144);

        // non-branch predicted taken
        ex_set(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        chk("nb_mis", {31'd0, mispredict}, 32'd1);
        chk("nb_redir", redirect_pc, 32'h104);
        step();
        ex_idle();
        look("nb_after", 32'h100, 1'b0, 32'h104);
        chk("nb_bcnt", branch_cnt, 32'd6);
        chk("nb_mcnt", mispred_cnt, 32'd5);

        // invalid EX line: no mispredict, no counts, no training
        ex_set(1'b0, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h90);
        chk("inv_mis", {31'd0, mispredict}, 32'd0);
        step();
        ex_idle();
        look("inv_after", 32'h100, 1'b0, 32'h104);
        chk("inv_bcnt", branch_cnt, 32'd6);
        chk("inv_mcnt", mispred_cnt, 32'd5);

        // not-taken miss leaves table alone
        ex_set(1'b1, 1'b1, 1'b0, 32'h300, 32'h40, 1'b0, 32'h304);
        chk("ntmiss_mis", {31'd0, mispredict}, 32'd0);
        step();
        ex_idle();
        look("ntmiss_after", 32'h300, 1'b0, 32'h304);

        // PC wrap
        look("wrap_if", 32'hFFFF_FFFC, 1'b0, 32'h0);
        ex_set(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        chk("wrap_ex", redirect_pc, 32'h0);

        // reset mid-operation discards the same-cycle update
        ex_set(1'b1, 1'b1, 1'b1, 32'h200, 32'h40, 1'b0, 32'h204);
        rst = 1'b1;
        #1;
        chk("rstmid_mis", {31'd0, mispredict}, 32'd1);
        step();
        rst = 1'b0;
        ex_idle();
        look("rstmid_after", 32'h200, 1'b0, 32'h204);
        chk("rstmid_bcnt", branch_cnt, 32'd0);
        chk("rstmid_mcnt", mispred_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
